// File: rtl/bp_stream_to_burst_gearbox_if.sv
// Bus bundle for the stream-to-burst gearbox: the stream input channel
// (header + data beat, ready-valid-and) and the two burst output channels
// (header, data + last).
//
// Handshake semantics for every channel: a transfer happens on a rising clock
// edge where valid and ready are both high. Valid never depends on ready.
// Payload must be held stable while valid is high and ready is low.
interface bp_stream_to_burst_gearbox_if #(
    parameter int hdr_width_p      = 67,
    parameter int in_data_width_p  = 64,
    parameter int out_data_width_p = 256
);
    // Stream side
    logic [hdr_width_p-1:0]      in_msg_header_i;
    logic [in_data_width_p-1:0]  in_msg_data_i;
    logic                        in_msg_v_i;
    logic                        in_msg_ready_and_o;
    logic                        in_msg_last_i;

    // Burst side
    logic [hdr_width_p-1:0]      out_msg_header_o;
    logic                        out_msg_header_v_o;
    logic                        out_msg_header_ready_and_i;
    logic [out_data_width_p-1:0] out_msg_data_o;
    logic                        out_msg_data_v_o;
    logic                        out_msg_data_ready_and_i;
    logic                        out_msg_last_o;

    // Gearbox view: consumes the stream, produces the burst channels
    modport slave (
        input  in_msg_header_i,
        input  in_msg_data_i,
        input  in_msg_v_i,
        output in_msg_ready_and_o,
        input  in_msg_last_i,
        output out_msg_header_o,
        output out_msg_header_v_o,
        input  out_msg_header_ready_and_i,
        output out_msg_data_o,
        output out_msg_data_v_o,
        input  out_msg_data_ready_and_i,
        output out_msg_last_o
    );

    // Environment view: produces the stream, consumes the burst channels
    modport master (
        output in_msg_header_i,
        output in_msg_data_i,
        output in_msg_v_i,
        input  in_msg_ready_and_o,
        output in_msg_last_i,
        input  out_msg_header_o,
        input  out_msg_header_v_o,
        output out_msg_header_ready_and_i,
        input  out_msg_data_o,
        input  out_msg_data_v_o,
        output out_msg_data_ready_and_i,
        input  out_msg_last_o
    );
endinterface

// File: rtl/bp_stream_to_burst_gearbox.sv
// BedRock Stream -> Burst gearbox.
// Each accepted stream beat carries the message header plus one narrow data
// beat. The header is captured once per message into a registered header
// channel; data beats are packed low-slot-first into a wide register and
// released as one burst beat per N stream beats (or earlier on the final
// beat, zero-padded in the unwritten high slots).
//
// Header layout (LSB first): msg_type[3:0], subop[3:0], size[2:0],
// addr[paddr_width_p-1:0], payload[payload_width_p-1:0]. The processor
// configuration is reduced to the paddr/payload widths it would supply.
module bp_stream_to_burst_gearbox #(
    parameter int          paddr_width_p    = 40,
    parameter int          payload_width_p  = 16,
    parameter int          in_data_width_p  = 64,
    parameter int          out_data_width_p = 256,
    parameter logic [15:0] payload_mask_p   = '0
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    bp_stream_to_burst_gearbox_if.slave bus
);

    localparam int n_lp          = out_data_width_p / in_data_width_p;
    localparam int cnt_width_lp  = (n_lp > 1) ? $clog2(n_lp) : 1;
    localparam int hdr_width_lp  = payload_width_p + paddr_width_p + 3 + 4 + 4;

    typedef struct packed {
        logic [payload_width_p-1:0] payload;
        logic [paddr_width_p-1:0]   addr;
        logic [2:0]                 size;
        logic [3:0]                 subop;
        logic [3:0]                 msg_type;
    } hdr_s;

    // State
    hdr_s                                    hdr_q, hdr_d;
    logic                                    hdr_v_q, hdr_v_d;
    logic                                    streaming_q, streaming_d;
    logic [cnt_width_lp-1:0]                 cnt_q, cnt_d;
    logic [n_lp-1:0][in_data_width_p-1:0]    data_q, data_d;
    logic                                    data_v_q, data_v_d;
    logic                                    last_q, last_d;

    // Decoded inputs and handshake terms
    hdr_s in_hdr;
    logic has_data;
    logic hdr_ok;
    logic data_ok;
    logic in_ready;
    logic accept;
    logic beat_done;

    assign in_hdr   = bus.in_msg_header_i;
    assign has_data = payload_mask_p[in_hdr.msg_type];

    // A register can take new content when empty or draining this cycle.
    assign hdr_ok   = ~hdr_v_q  | bus.out_msg_header_ready_and_i;
    assign data_ok  = ~data_v_q | bus.out_msg_data_ready_and_i;

    // data_ok gates every beat (including header-only messages) so that a new
    // header can never overtake the previous message's final data beat.
    assign in_ready = data_ok & (streaming_q | hdr_ok);
    assign accept   = bus.in_msg_v_i & in_ready;

    // With N=1 the counter is a constant zero, so every beat completes a word.
    assign beat_done = (cnt_q == cnt_width_lp'(n_lp - 1)) | bus.in_msg_last_i;

    // Next-state: dequeue on output handshakes, then load from an accepted beat.
    always_comb begin
        hdr_d       = hdr_q;
        hdr_v_d     = hdr_v_q;
        streaming_d = streaming_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        data_v_d    = data_v_q;
        last_d      = last_q;

        if (hdr_v_q && bus.out_msg_header_ready_and_i) begin
            hdr_v_d = 1'b0;
        end
        if (data_v_q && bus.out_msg_data_ready_and_i) begin
            data_v_d = 1'b0;
        end

        if (accept) begin
            streaming_d = ~bus.in_msg_last_i;

            if (!streaming_q) begin
                hdr_d   = in_hdr;
                hdr_v_d = 1'b1;
            end

            if (has_data) begin
                // Starting a new burst word: clear so short messages pad with zeros.
                if (cnt_q == '0) begin
                    data_d = '0;
                end
                data_d[cnt_q] = bus.in_msg_data_i;

                if (beat_done) begin
                    data_v_d = 1'b1;
                    last_d   = bus.in_msg_last_i;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

    // State registers, cleared asynchronously so a mid-message reset drops partial words.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            hdr_q       <= '0;
            hdr_v_q     <= 1'b0;
            streaming_q <= 1'b0;
            cnt_q       <= '0;
            data_q      <= '0;
            data_v_q    <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            hdr_q       <= hdr_d;
            hdr_v_q     <= hdr_v_d;
            streaming_q <= streaming_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            data_v_q    <= data_v_d;
            last_q      <= last_d;
        end
    end

    assign bus.in_msg_ready_and_o = in_ready;
    assign bus.out_msg_header_o   = hdr_q;
    assign bus.out_msg_header_v_o = hdr_v_q;
    assign bus.out_msg_data_o     = data_q;
    assign bus.out_msg_data_v_o   = data_v_q;
    assign bus.out_msg_last_o     = last_q;

    // Width configuration: whole number of narrow beats, power-of-two ratio,
    // and an interface header width that matches the header layout.
    a_cfg: assert property (@(posedge clk_i)
        ((out_data_width_p % in_data_width_p) == 0) &&
        ((n_lp & (n_lp - 1)) == 0) &&
        ($bits(bus.in_msg_header_i) == hdr_width_lp));

    // The header presented with later beats must match the captured one.
    a_hdr_stable: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        (streaming_q && bus.in_msg_v_i) |-> (in_hdr == hdr_q));

    // A message type without data is a single-beat message.
    a_nodata_last: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        (accept && !has_data) |-> bus.in_msg_last_i);

endmodule

// File: tb/tb_bp_stream_to_burst_gearbox.sv
// Directed bench for the stream-to-burst gearbox (64-bit in, 256-bit out, N=4).
// Message type 1 carries data; types 0 and 2 are header-only.
module tb_bp_stream_to_burst_gearbox;

    localparam int          IW   = 64;
    localparam int          OW   = 256;
    localparam int          PA   = 40;
    localparam int          PL   = 16;
    localparam int          HW   = PL + PA + 3 + 4 + 4;
    localparam logic [15:0] MASK = 16'h0002;

    // Clock / reset
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bp_stream_to_burst_gearbox_if #(
        .hdr_width_p     (HW),
        .in_data_width_p (IW),
        .out_data_width_p(OW)
    ) bus ();

    bp_stream_to_burst_gearbox #(
        .paddr_width_p   (PA),
        .payload_width_p (PL),
        .in_data_width_p (IW),
        .out_data_width_p(OW),
        .payload_mask_p  (MASK)
    ) u_dut (
        .clk_i    (clk),
        .reset_n_i(rst_n),
        .bus      (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        string           name;
        logic            v;
        logic            last;
        logic [HW-1:0]   hdr;
        logic [IW-1:0]   data;
        logic            hrdy;
        logic            drdy;
        logic            e_rdy;
        logic            e_hv;
        logic [HW-1:0]   e_hdr;
        logic            e_dv;
        logic            e_last;
        logic [OW-1:0]   e_data;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [HW-1:0] mk_hdr(input logic [3:0] typ, input logic [39:0] addr);
        return {16'hBEEF, addr, 3'd6, 4'd0, typ};
    endfunction

    function automatic logic [IW-1:0] beat(input int tag, input int i);
        return {8'(tag), 8'(i), 48'h0123_4567_89AB};
    endfunction

    function automatic logic [OW-1:0] burst(input logic [IW-1:0] s0, input logic [IW-1:0] s1,
                                            input logic [IW-1:0] s2, input logic [IW-1:0] s3);
        return {s3, s2, s1, s0};
    endfunction

    task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input string name, input logic v, input logic last,
                       input logic [HW-1:0] hdr, input logic [IW-1:0] data,
                       input logic hrdy, input logic drdy,
                       input logic e_rdy, input logic e_hv, input logic [HW-1:0] e_hdr,
                       input logic e_dv, input logic e_last, input logic [OW-1:0] e_data);
        vec_t t;
        t.name = name; t.v = v; t.last = last; t.hdr = hdr; t.data = data;
        t.hrdy = hrdy; t.drdy = drdy; t.e_rdy = e_rdy; t.e_hv = e_hv; t.e_hdr = e_hdr;
        t.e_dv = e_dv; t.e_last = e_last; t.e_data = e_data;
        vecs.push_back(t);
    endtask

    // Driver
    task automatic drive(input logic v, input logic last, input logic [HW-1:0] hdr,
                         input logic [IW-1:0] data, input logic hrdy, input logic drdy);
        bus.in_msg_v_i                 = v;
        bus.in_msg_last_i              = last;
        bus.in_msg_header_i            = hdr;
        bus.in_msg_data_i              = data;
        bus.out_msg_header_ready_and_i = hrdy;
        bus.out_msg_data_ready_and_i   = drdy;
    endtask

    // One table row: ready is checked before the edge, registered outputs after it.
    task automatic apply(input vec_t t);
        drive(t.v, t.last, t.hdr, t.data, t.hrdy, t.drdy);
        #1;
        chk($sformatf("%s.ready", t.name), OW'(bus.in_msg_ready_and_o), OW'(t.e_rdy));
        @(posedge clk);
        #1;
        chk($sformatf("%s.hdr_v", t.name), OW'(bus.out_msg_header_v_o), OW'(t.e_hv));
        if (t.e_hv) chk($sformatf("%s.hdr", t.name), OW'(bus.out_msg_header_o), OW'(t.e_hdr));
        chk($sformatf("%s.data_v", t.name), OW'(bus.out_msg_data_v_o), OW'(t.e_dv));
        if (t.e_dv) begin
            chk($sformatf("%s.data", t.name), bus.out_msg_data_o, t.e_data);
            chk($sformatf("%s.last", t.name), OW'(bus.out_msg_last_o), OW'(t.e_last));
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk($sformatf("%s.hdr_v", tag),  OW'(bus.out_msg_header_v_o), '0);
        chk($sformatf("%s.data_v", tag), OW'(bus.out_msg_data_v_o), '0);
        chk($sformatf("%s.last", tag),   OW'(bus.out_msg_last_o), '0);
        chk($sformatf("%s.hdr", tag),    OW'(bus.out_msg_header_o), '0);
        chk($sformatf("%s.data", tag),   bus.out_msg_data_o, '0);
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

    initial begin
        logic [HW-1:0] ha, hr, hb, hc, hx, hy, hk, hr2, hg, hh;
        logic [IW-1:0] junk;
        ha  = mk_hdr(4'd1, 40'h10_0000_0040);
        hr  = mk_hdr(4'd0, 40'h20_0000_0080);
        hb  = mk_hdr(4'd1, 40'h30_0000_00C0);
        hc  = mk_hdr(4'd1, 40'h40_0000_0100);
        hx  = mk_hdr(4'd0, 40'h50_0000_0140);
        hy  = mk_hdr(4'd2, 40'h60_0000_0180);
        hk  = mk_hdr(4'd1, 40'h70_0000_01C0);
        hr2 = mk_hdr(4'd0, 40'h80_0000_0200);
        hg  = mk_hdr(4'd1, 40'h90_0000_0240);
        hh  = mk_hdr(4'd1, 40'hA0_0000_0280);
        junk = 64'hDEAD_BEEF_DEAD_BEEF;

        // Full 8-beat write, sinks always ready
        for (int i = 0; i < 8; i++) begin
            logic dv;
            dv = (i == 3) || (i == 7);
            add($sformatf("wr8_b%0d", i), 1'b1, (i == 7), ha, beat(1, i), 1'b1, 1'b1,
                1'b1, (i == 0), ha, dv, (i == 7),
                (i == 3) ? burst(beat(1, 0), beat(1, 1), beat(1, 2), beat(1, 3))
                         : burst(beat(1, 4), beat(1, 5), beat(1, 6), beat(1, 7)));
        end
        add("wr8_idle", 1'b0, 1'b0, ha, '0, 1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0, '0);

        // Header-only read
        add("rd_b0",   1'b1, 1'b1, hr, junk, 1'b1, 1'b1, 1'b1, 1'b1, hr, 1'b0, 1'b0, '0);
        add("rd_idle", 1'b0, 1'b0, hr, '0,   1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0, '0);

        // Short 2-beat write: zero-padded single burst beat
        add("wr2_b0",   1'b1, 1'b0, hb, beat(3, 0), 1'b1, 1'b1, 1'b1, 1'b1, hb, 1'b0, 1'b0, '0);
        add("wr2_b1",   1'b1, 1'b1, hb, beat(3, 1), 1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b1,
            burst(beat(3, 0), beat(3, 1), '0, '0));
        add("wr2_idle", 1'b0, 1'b0, hb, '0, 1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0, '0);

        // Data sink stalled for 5 cycles with a full word pending
        for (int i = 0; i < 4; i++) begin
            add($sformatf("dst_b%0d", i), 1'b1, 1'b0, hc, beat(4, i), 1'b1, 1'b0,
                1'b1, (i == 0), hc, (i == 3), 1'b0,
                burst(beat(4, 0), beat(4, 1), beat(4, 2), beat(4, 3)));
        end
        for (int i = 0; i < 5; i++) begin
            add($sformatf("dst_stall%0d", i), 1'b1, 1'b0, hc, beat(4, 4), 1'b1, 1'b0,
                1'b0, 1'b0, '0, 1'b1, 1'b0,
                burst(beat(4, 0), beat(4, 1), beat(4, 2), beat(4, 3)));
        end
        for (int i = 4; i < 8; i++) begin
            add($sformatf("dst_b%0d", i), 1'b1, (i == 7), hc, beat(4, i), 1'b1, 1'b1,
                1'b1, 1'b0, '0, (i == 7), 1'b1,
                burst(beat(4, 4), beat(4, 5), beat(4, 6), beat(4, 7)));
        end
        add("dst_idle", 1'b0, 1'b0, hc, '0, 1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0, '0);

        // Header sink stalled, two back-to-back header-only messages
        add("hst_a",    1'b1, 1'b1, hx, junk, 1'b0, 1'b1, 1'b1, 1'b1, hx, 1'b0, 1'b0, '0);
        add("hst_b0",   1'b1, 1'b1, hy, junk, 1'b0, 1'b1, 1'b0, 1'b1, hx, 1'b0, 1'b0, '0);
        add("hst_b1",   1'b1, 1'b1, hy, junk, 1'b0, 1'b1, 1'b0, 1'b1, hx, 1'b0, 1'b0, '0);
        add("hst_b2",   1'b1, 1'b1, hy, junk, 1'b1, 1'b1, 1'b1, 1'b1, hy, 1'b0, 1'b0, '0);
        add("hst_idle", 1'b0, 1'b0, hy, '0,   1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0, '0);

        // Ordering: next header waits for the pending final data beat to drain
        add("ord_w0",   1'b1, 1'b0, hk,  beat(7, 0), 1'b1, 1'b0, 1'b1, 1'b1, hk, 1'b0, 1'b0, '0);
        add("ord_w1",   1'b1, 1'b1, hk,  beat(7, 1), 1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b1,
            burst(beat(7, 0), beat(7, 1), '0, '0));
        add("ord_rd0",  1'b1, 1'b1, hr2, junk, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1,
            burst(beat(7, 0), beat(7, 1), '0, '0));
        add("ord_rd1",  1'b1, 1'b1, hr2, junk, 1'b1, 1'b1, 1'b1, 1'b1, hr2, 1'b0, 1'b0, '0);
        add("ord_idle", 1'b0, 1'b0, hr2, '0,   1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0, '0);

        // Reset phase
        drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("in_reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all_zero("post_reset");

        // Table
        foreach (vecs[i]) apply(vecs[i]);

        // Reset mid-message with two slots filled
        drive(1'b1, 1'b0, hg, beat(9, 0), 1'b1, 1'b1);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, hg, beat(9, 1), 1'b1, 1'b1);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, hg, '0, 1'b1, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        drive(1'b1, 1'b0, hh, beat(10, 0), 1'b1, 1'b1);
        #1;
        chk("rst_h0.ready", OW'(bus.in_msg_ready_and_o), OW'(1'b1));
        @(posedge clk); #1;
        chk("rst_h0.hdr_v",  OW'(bus.out_msg_header_v_o), OW'(1'b1));
        chk("rst_h0.hdr",    OW'(bus.out_msg_header_o), OW'(hh));
        chk("rst_h0.data_v", OW'(bus.out_msg_data_v_o), '0);
        drive(1'b1, 1'b1, hh, beat(10, 1), 1'b1, 1'b1);
        @(posedge clk); #1;
        chk("rst_h1.data_v", OW'(bus.out_msg_data_v_o), OW'(1'b1));
        chk("rst_h1.data",   bus.out_msg_data_o, burst(beat(10, 0), beat(10, 1), '0, '0));
        chk("rst_h1.last",   OW'(bus.out_msg_last_o), OW'(1'b1));
        drive(1'b0, 1'b0, hh, '0, 1'b1, 1'b1);
        @(posedge clk); #1;
        chk("rst_idle.data_v", OW'(bus.out_msg_data_v_o), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
